cnn_window_gen: RTL and testbench
=================================

# cnn_window_gen

Parametrised sliding-window generator for the CNN front end. It takes a raster-ordered pixel stream of CI channels over an IX×IY frame and buffers KY-1 lines internally. For each valid KX×KY window position at the configured stride, it emits one full window per handshake. It sits between the image source and the stage-1 convolution core. It replaces the fixed 5×5, single-channel, no-backpressure window logic with configurable kernel size, channel count and stride, valid/ready flow control, and frame framing.

## Interface
- I_F_BW, 8, bits per channel sample
- CI, 1, channels per pixel
- IX, 28, frame width in pixels
- IY, 28, frame height in pixels
- KX, 5, window width (2..IX)
- KY, 5, window height (2..IY)
- STRIDE, 1, window step in both x and y (1..KX)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- i_valid  in  1  input pixel valid
- i_sof  in  1  start of frame; qualifies the accepted pixel as (0,0)
- i_pixel  in  CI*I_F_BW  pixel; channel ch at [ch*I_F_BW +: I_F_BW]
- i_ready  out  1  block can accept a pixel this cycle
- o_valid  out  1  o_window holds a valid window
- o_ready  in  1  downstream accepts the window
- o_window  out  KX*KY*CI*I_F_BW  element (r,c) at index idx=r*KX+c, bits [idx*CI*I_F_BW +: CI*I_F_BW]; r=0 is the oldest row, c=0 is the leftmost column
- o_win_x  out  $clog2(IX)  window index along x (0..OUT_W-1)
- o_win_y  out  $clog2(IY)  window index along y (0..OUT_H-1)
- o_last  out  1  window is the last one of the frame

## Operation
- OUT_W = (IX-KX)/STRIDE+1, OUT_H = (IY-KY)/STRIDE+1. Both use integer division.
- Accept condition: i_valid && i_ready. i_ready = !o_valid || o_ready. It is combinational from the output register state.
- Column counter col runs 0..IX-1. Row counter row runs 0..IY-1. Both advance on each accept. col wraps to 0 and row increments at the end of a line. Both wrap to (0,0) after pixel (IY-1,IX-1).
- If i_sof=1 on an accept, that pixel is (0,0) regardless of the counters. After it, col=1 and row=0.
- Storage: KY-1 line buffers of IX pixels each, plus a KX-deep column shift register per row. A window is assembled from the current pixel and its KY-1 vertical predecessors.
- Window emit: an accepted pixel at (row,col) completes a window if all of the following hold:
  - row≥KY-1 and col≥KX-1
  - (row-KY+1) is a multiple of STRIDE
  - (col-KX+1) is a multiple of STRIDE
  - Use phase counters for the stride test; no modulo hardware.
- On emit:
  - o_window, o_win_x=(col-KX+1)/STRIDE, o_win_y=(row-KY+1)/STRIDE are registered and o_valid is set.
  - o_last=1 if o_win_x=OUT_W-1 and o_win_y=OUT_H-1.
- Output register clears (o_valid←0) on o_valid && o_ready when no new window is emitted in the same cycle. A simultaneous accept-and-emit overwrites the register and keeps o_valid=1.
- While o_valid && !o_ready: i_ready=0. o_window, o_win_x, o_win_y and o_last are held stable. No pixel is lost.
- Reset:
  - All outputs go to 0: o_valid, o_window, o_win_x, o_win_y, o_last.
  - i_ready is 1 in the first cycle after reset.
  - Counters go to (0,0) and phase counters are cleared.
  - Line-buffer contents are don't-care. Stale data is never emitted because emission needs KY-1 rows written after reset or after i_sof.
- Reset mid-frame aborts the frame. The next accepted pixel is treated as (0,0).

## Timing
- Latency: o_valid rises on the clock edge that accepts the completing pixel, and is visible the following cycle.
- Throughput: 1 pixel/cycle when o_ready=1 continuously. Back-to-back frames need no idle cycle.
- Pixels stall only while a window is held unaccepted. Input stall length equals downstream stall length.
- Frame of IX×IY pixels yields exactly OUT_W×OUT_H windows. o_last is on the last of these.

## Test plan
- Default params, o_ready=1, i_pixel=(row*28+col)&8'hFF:
  - First o_valid follows the accept of (4,4), with window[0]=0, window[24]=116, win_x=0, win_y=0.
  - 576 windows total; o_last only on #576 (win 23,23).
- Backpressure: drop o_ready for 10 cycles on window #3.
  - i_ready=0 throughout, and o_window/o_win_x are stable.
  - Remaining windows carry correct values; total is still 576.
- STRIDE=2, default size:
  - 144 windows, coordinates (0,0)..(11,11).
  - Second window's window[0] equals pixel (0,2)=2.
- CI=3, KX=KY=3, IX=IY=8, channel ch=ch*64+row*8+col:
  - 36 windows; channel 2 of window[4] of window (0,0) = 128+9=137.
- Reset asserted at pixel (10,3), then a fresh frame:
  - No window before pixel (4,4) of the new frame; 576 windows follow.
- i_sof asserted at pixel (6,7) of a running frame:
  - The pixel is treated as (0,0); no window is emitted until (4,4) after the restart.
  - Then two back-to-back frames, with no gap and 576 windows each.

Source files
------------

// File: rtl/cnn_window_gen.sv
// Sliding-window generator: buffers KY-1 lines of a raster pixel stream and emits
// each KX x KY window at the configured stride through a valid/ready output register.
module cnn_window_gen #(
  parameter int I_F_BW = 8,
  parameter int CI     = 1,
  parameter int IX     = 28,
  parameter int IY     = 28,
  parameter int KX     = 5,
  parameter int KY     = 5,
  parameter int STRIDE = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_valid,
  input  logic                            i_sof,
  input  logic [CI*I_F_BW-1:0]            i_pixel,
  output logic                            i_ready,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [KX*KY*CI*I_F_BW-1:0]      o_window,
  output logic [$clog2(IX)-1:0]           o_win_x,
  output logic [$clog2(IY)-1:0]           o_win_y,
  output logic                            o_last
);

  localparam int PW    = CI * I_F_BW;
  localparam int WW    = KX * KY * PW;
  localparam int CW    = $clog2(IX);
  localparam int RW    = $clog2(IY);
  localparam int PHW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int OUT_W = (IX - KX) / STRIDE + 1;
  localparam int OUT_H = (IY - KY) / STRIDE + 1;

  localparam logic [CW-1:0]  COL_LAST      = CW'(IX - 1);
  localparam logic [CW-1:0]  COL_FIRST_WIN = CW'(KX - 1);
  localparam logic [RW-1:0]  ROW_LAST      = RW'(IY - 1);
  localparam logic [RW-1:0]  ROW_FIRST_WIN = RW'(KY - 1);
  localparam logic [PHW-1:0] PH_LAST       = PHW'(STRIDE - 1);
  localparam logic [CW-1:0]  WX_LAST       = CW'(OUT_W - 1);
  localparam logic [RW-1:0]  WY_LAST       = RW'(OUT_H - 1);

  logic [CW-1:0]  col_q, col_e, wx_q, wx_e;
  logic [RW-1:0]  row_q, row_e, wy_q, wy_e;
  logic [PHW-1:0] xph_q, xph_e, yph_q, yph_e;
  logic           accept, x_hit, y_hit, emit, eol;

  logic [PW-1:0]  line_buf [KY-1][IX];
  logic [PW-1:0]  shift_q  [KY][KX];
  logic [PW-1:0]  shift_d  [KY][KX];
  logic [PW-1:0]  col_vec  [KY];
  logic [WW-1:0]  window_d;

  assign i_ready = !o_valid || o_ready;
  assign accept  = i_valid && i_ready;

  // i_sof forces the pixel to (0,0) with all phase and window-index state cleared
  always_comb begin
    col_e = i_sof ? '0 : col_q;
    row_e = i_sof ? '0 : row_q;
    xph_e = i_sof ? '0 : xph_q;
    yph_e = i_sof ? '0 : yph_q;
    wx_e  = i_sof ? '0 : wx_q;
    wy_e  = i_sof ? '0 : wy_q;
    x_hit = (col_e >= COL_FIRST_WIN) && (xph_e == '0);
    y_hit = (row_e >= ROW_FIRST_WIN) && (yph_e == '0);
    eol   = (col_e == COL_LAST);
    emit  = accept && x_hit && y_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      xph_q <= '0;
      yph_q <= '0;
      wx_q  <= '0;
      wy_q  <= '0;
    end else if (accept) begin
      if (eol) begin
        col_q <= '0;
        xph_q <= '0;
        wx_q  <= '0;
        if (row_e == ROW_LAST) begin
          row_q <= '0;
          yph_q <= '0;
          wy_q  <= '0;
        end else begin
          row_q <= row_e + RW'(1);
          if (row_e >= ROW_FIRST_WIN) begin
            yph_q <= (yph_e == PH_LAST) ? '0 : yph_e + PHW'(1);
            wy_q  <= wy_e + RW'(y_hit);
          end else begin
            yph_q <= yph_e;
            wy_q  <= wy_e;
          end
        end
      end else begin
        col_q <= col_e + CW'(1);
        row_q <= row_e;
        yph_q <= yph_e;
        wy_q  <= wy_e;
        if (col_e >= COL_FIRST_WIN) begin
          xph_q <= (xph_e == PH_LAST) ? '0 : xph_e + PHW'(1);
          wx_q  <= wx_e + CW'(x_hit);
        end else begin
          xph_q <= xph_e;
          wx_q  <= wx_e;
        end
      end
    end
  end

  // Vertical column: KY-1 buffered predecessors (oldest first) then the live pixel
  always_comb begin
    for (int r = 0; r < KY - 1; r++) begin
      col_vec[r] = line_buf[r][col_e];
    end
    col_vec[KY-1] = i_pixel;
  end

  always_comb begin
    for (int r = 0; r < KY; r++) begin
      for (int c = 0; c < KX - 1; c++) begin
        shift_d[r][c] = shift_q[r][c+1];
      end
      shift_d[r][KX-1] = col_vec[r];
    end
  end

  always_comb begin
    window_d = '0;
    for (int r = 0; r < KY; r++) begin
      for (int c = 0; c < KX; c++) begin
        window_d[(r*KX + c)*PW +: PW] = shift_d[r][c];
      end
    end
  end

  // Storage carries no reset; emission needs KY-1 freshly written rows anyway
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KY - 1; r++) begin
        line_buf[r][col_e] <= col_vec[r+1];
      end
      for (int r = 0; r < KY; r++) begin
        for (int c = 0; c < KX; c++) begin
          shift_q[r][c] <= shift_d[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid  <= 1'b0;
      o_window <= '0;
      o_win_x  <= '0;
      o_win_y  <= '0;
      o_last   <= 1'b0;
    end else if (emit) begin
      o_valid  <= 1'b1;
      o_window <= window_d;
      o_win_x  <= wx_e;
      o_win_y  <= wy_e;
      o_last   <= (wx_e == WX_LAST) && (wy_e == WY_LAST);
    end else if (o_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen: three parameterisations checked against a frame-array
// window model, with table-driven frames plus backpressure, reset and sof sequences.
`timescale 1ns/1ps
module tb_cnn_window_gen;

  localparam int NI   = 3;
  localparam int MAXW = 216;

  typedef struct {
    int               k;
    logic [MAXW-1:0]  win;
    int               wx;
    int               wy;
    bit               last;
  } exp_t;

  typedef struct {
    int k;
    bit rnd;
    int vpct;
    int rpct;
    int exp_cnt;
    int exp_lx;
    int exp_ly;
  } vec_t;

  // instance 0: defaults, 1: stride 2, 2: CI=3 3x3 kernel on 8x8
  int P_IX [NI] = '{28, 28, 8};
  int P_IY [NI] = '{28, 28, 8};
  int P_KX [NI] = '{5, 5, 3};
  int P_KY [NI] = '{5, 5, 3};
  int P_S  [NI] = '{1, 2, 1};
  int P_PW [NI] = '{8, 8, 24};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            iv [NI];
  logic            isof [NI];
  logic            ordy [NI];
  logic [23:0]     ipix [NI];
  logic            irdy [NI];
  logic            ov [NI];
  logic            olast [NI];
  logic [MAXW-1:0] owin [NI];
  logic [7:0]      owx [NI];
  logic [7:0]      owy [NI];

  logic irdy_a, irdy_b, irdy_c, ov_a, ov_b, ov_c, last_a, last_b, last_c;
  logic [199:0] win_a, win_b;
  logic [215:0] win_c;
  logic [4:0] wx_a, wy_a, wx_b, wy_b;
  logic [2:0] wx_c, wy_c;

  cnn_window_gen u_a (
    .clk(clk), .reset_n(rst_n), .i_valid(iv[0]), .i_sof(isof[0]), .i_pixel(ipix[0][7:0]),
    .i_ready(irdy_a), .o_valid(ov_a), .o_ready(ordy[0]), .o_window(win_a),
    .o_win_x(wx_a), .o_win_y(wy_a), .o_last(last_a));

  cnn_window_gen #(.STRIDE(2)) u_b (
    .clk(clk), .reset_n(rst_n), .i_valid(iv[1]), .i_sof(isof[1]), .i_pixel(ipix[1][7:0]),
    .i_ready(irdy_b), .o_valid(ov_b), .o_ready(ordy[1]), .o_window(win_b),
    .o_win_x(wx_b), .o_win_y(wy_b), .o_last(last_b));

  cnn_window_gen #(.CI(3), .IX(8), .IY(8), .KX(3), .KY(3)) u_c (
    .clk(clk), .reset_n(rst_n), .i_valid(iv[2]), .i_sof(isof[2]), .i_pixel(ipix[2]),
    .i_ready(irdy_c), .o_valid(ov_c), .o_ready(ordy[2]), .o_window(win_c),
    .o_win_x(wx_c), .o_win_y(wy_c), .o_last(last_c));

  assign irdy[0] = irdy_a;  assign irdy[1] = irdy_b;  assign irdy[2] = irdy_c;
  assign ov[0] = ov_a;      assign ov[1] = ov_b;      assign ov[2] = ov_c;
  assign olast[0] = last_a; assign olast[1] = last_b; assign olast[2] = last_c;
  assign owin[0] = MAXW'(win_a);
  assign owin[1] = MAXW'(win_b);
  assign owin[2] = win_c;
  assign owx[0] = 8'(wx_a); assign owx[1] = 8'(wx_b); assign owx[2] = 8'(wx_c);
  assign owy[0] = 8'(wy_a); assign owy[1] = 8'(wy_b); assign owy[2] = 8'(wy_c);

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  int          pos [NI];
  logic [23:0] frame [NI][28][28];
  int          rx_cnt [NI], rx_base [NI], last_cnt [NI], last_x [NI], last_y [NI];
  logic [MAXW-1:0] log0 [NI], log1 [NI];
  bit              hold_v [NI];
  logic [MAXW-1:0] hold_win [NI];
  logic [7:0]      hold_x [NI], hold_y [NI];
  logic            hold_l [NI];

  function automatic void chk(string name, logic [MAXW-1:0] act, logic [MAXW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [23:0] pat(int k, int r, int c);
    if (k == 2) return {8'(128 + r*8 + c), 8'(64 + r*8 + c), 8'(r*8 + c)};
    return 24'((r*28 + c) & 255);
  endfunction

  // Reference: store each accepted pixel at its raster position and cut windows out of the frame
  function automatic void model_accept(int k, logic sof, logic [23:0] pix);
    int r, c;
    exp_t e;
    if (sof) pos[k] = 0;
    r = pos[k] / P_IX[k];
    c = pos[k] % P_IX[k];
    frame[k][r][c] = pix;
    if (r >= P_KY[k]-1 && c >= P_KX[k]-1 &&
        (r - P_KY[k] + 1) % P_S[k] == 0 && (c - P_KX[k] + 1) % P_S[k] == 0) begin
      e.k = k;
      e.win = '0;
      for (int rr = 0; rr < P_KY[k]; rr++)
        for (int cc = 0; cc < P_KX[k]; cc++)
          e.win |= MAXW'(frame[k][r-P_KY[k]+1+rr][c-P_KX[k]+1+cc]) << ((rr*P_KX[k] + cc)*P_PW[k]);
      e.wx = (c - P_KX[k] + 1) / P_S[k];
      e.wy = (r - P_KY[k] + 1) / P_S[k];
      e.last = (e.wx == (P_IX[k]-P_KX[k])/P_S[k]) && (e.wy == (P_IY[k]-P_KY[k])/P_S[k]);
      q.push_back(e);
    end
    pos[k] = (pos[k] + 1) % (P_IX[k] * P_IY[k]);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) hold_v[k] = 1'b0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (hold_v[k]) begin
          chk($sformatf("held_valid_%0d", k), ov[k], 1);
          chk($sformatf("held_window_%0d", k), owin[k], hold_win[k]);
          chk($sformatf("held_win_x_%0d", k), owx[k], hold_x[k]);
          chk($sformatf("held_win_y_%0d", k), owy[k], hold_y[k]);
          chk($sformatf("held_last_%0d", k), olast[k], hold_l[k]);
        end
        chk($sformatf("i_ready_%0d", k), irdy[k], !(ov[k] && !ordy[k]));
        hold_v[k] = ov[k] && !ordy[k];
        hold_win[k] = owin[k];
        hold_x[k] = owx[k];
        hold_y[k] = owy[k];
        hold_l[k] = olast[k];
        if (ov[k] && ordy[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < q.size(); i++) begin
            if (idx < 0 && q[i].k == k) idx = i;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window_%0d: actual x=%0d y=%0d required none", k, owx[k], owy[k]);
          end else begin
            exp_t e;
            e = q[idx];
            q.delete(idx);
            chk($sformatf("window_%0d", k), owin[k], e.win);
            chk($sformatf("win_x_%0d", k), owx[k], e.wx);
            chk($sformatf("win_y_%0d", k), owy[k], e.wy);
            chk($sformatf("last_%0d", k), olast[k], e.last);
          end
          if (rx_cnt[k] - rx_base[k] == 0) log0[k] = owin[k];
          if (rx_cnt[k] - rx_base[k] == 1) log1[k] = owin[k];
          if (olast[k]) begin
            last_cnt[k]++;
            last_x[k] = int'(owx[k]);
            last_y[k] = int'(owy[k]);
          end
          rx_cnt[k]++;
        end
        if (iv[k] && irdy[k]) model_accept(k, isof[k], ipix[k]);
      end
    end
  end

  task automatic drive(input int k, input int n, input bit sof_first, input bit rnd,
                       input int vpct, input int rpct, input int stall_on, output int cycles);
    int sent, r, c, stall_left;
    bit first, stall_done, v;
    sent = 0; r = 0; c = 0; stall_left = 0;
    first = sof_first; stall_done = 0;
    cycles = 0;
    while (sent < n) begin
      @(posedge clk); #1;
      cycles++;
      if (stall_on >= 0 && !stall_done && ov[k] && (rx_cnt[k] - rx_base[k] == stall_on)) begin
        stall_left = 10;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        ordy[k] = 1'b0;
        stall_left--;
      end else begin
        ordy[k] = ($urandom_range(99) < rpct);
      end
      v = ($urandom_range(99) < vpct);
      iv[k] = v;
      isof[k] = first && v;
      ipix[k] = rnd ? ($urandom() & 24'((1 << P_PW[k]) - 1)) : pat(k, r, c);
      @(negedge clk);
      if (v && irdy[k]) begin
        sent++;
        first = 0;
        c++;
        if (c == P_IX[k]) begin
          c = 0;
          r++;
          if (r == P_IY[k]) r = 0;
        end
      end
      if (cycles > 20*n + 1000) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout_%0d: actual sent=%0d required %0d", k, sent, n);
        break;
      end
    end
    @(posedge clk); #1;
    iv[k] = 1'b0;
    isof[k] = 1'b0;
    ordy[k] = 1'b1;
  endtask

  task automatic drain(input int k);
    ordy[k] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!ov[k]) break;
    end
    if (ov[k]) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout_%0d: actual o_valid=1 required 0", k);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; isof[k] = 1'b0; ordy[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    for (int k = 0; k < NI; k++) pos[k] = 0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_o_valid_%0d", k), ov[k], 0);
      chk($sformatf("rst_o_window_%0d", k), owin[k], 0);
      chk($sformatf("rst_win_x_%0d", k), owx[k], 0);
      chk($sformatf("rst_win_y_%0d", k), owy[k], 0);
      chk($sformatf("rst_last_%0d", k), olast[k], 0);
      chk($sformatf("rst_i_ready_%0d", k), irdy[k], 1);
      ordy[k] = 1'b1;
    end
  endtask

  vec_t vecs [6];

  initial begin
    int cyc, lb, n;
    vecs[0] = '{k: 0, rnd: 0, vpct: 100, rpct: 100, exp_cnt: 576, exp_lx: 23, exp_ly: 23};
    vecs[1] = '{k: 1, rnd: 0, vpct: 100, rpct: 100, exp_cnt: 144, exp_lx: 11, exp_ly: 11};
    vecs[2] = '{k: 2, rnd: 0, vpct: 100, rpct: 100, exp_cnt: 36,  exp_lx: 5,  exp_ly: 5};
    vecs[3] = '{k: 0, rnd: 1, vpct: 70,  rpct: 60,  exp_cnt: 576, exp_lx: 23, exp_ly: 23};
    vecs[4] = '{k: 1, rnd: 1, vpct: 60,  rpct: 50,  exp_cnt: 144, exp_lx: 11, exp_ly: 11};
    vecs[5] = '{k: 2, rnd: 1, vpct: 50,  rpct: 40,  exp_cnt: 36,  exp_lx: 5,  exp_ly: 5};

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 0; isof[k] = 0; ordy[k] = 0; ipix[k] = '0;
      pos[k] = 0; rx_cnt[k] = 0; rx_base[k] = 0; last_cnt[k] = 0;
      last_x[k] = 0; last_y[k] = 0; hold_v[k] = 0;
      log0[k] = '0; log1[k] = '0;
    end
    do_reset();

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vecs[i];
      n = P_IX[v.k] * P_IY[v.k];
      rx_base[v.k] = rx_cnt[v.k];
      lb = last_cnt[v.k];
      drive(v.k, n, 1, v.rnd, v.vpct, v.rpct, -1, cyc);
      drain(v.k);
      chk($sformatf("win_count_v%0d", i), rx_cnt[v.k] - rx_base[v.k], v.exp_cnt);
      chk($sformatf("last_count_v%0d", i), last_cnt[v.k] - lb, 1);
      chk($sformatf("last_x_v%0d", i), last_x[v.k], v.exp_lx);
      chk($sformatf("last_y_v%0d", i), last_y[v.k], v.exp_ly);
      if (v.vpct == 100 && v.rpct == 100)
        chk($sformatf("throughput_v%0d", i), cyc, n);
      if (!v.rnd) begin
        if (v.k == 0) begin
          chk("first_win_elem0", log0[0][7:0], 0);
          chk("first_win_elem24", log0[0][24*8 +: 8], 116);
        end else if (v.k == 1) begin
          chk("stride2_second_elem0", log1[1][7:0], 2);
        end else begin
          chk("ci3_elem4_ch2", log0[2][4*24 + 16 +: 8], 137);
        end
      end
    end

    // Ten-cycle downstream stall on window #3: input stalls exactly as long
    rx_base[0] = rx_cnt[0];
    lb = last_cnt[0];
    drive(0, 784, 1, 0, 100, 100, 2, cyc);
    drain(0);
    chk("bp_win_count", rx_cnt[0] - rx_base[0], 576);
    chk("bp_last_count", last_cnt[0] - lb, 1);
    chk("bp_cycles", cyc, 794);

    // Reset after pixel (10,3), then a fresh frame without sof
    drive(0, 10*28 + 4, 1, 0, 100, 100, -1, cyc);
    do_reset();
    rx_base[0] = rx_cnt[0];
    lb = last_cnt[0];
    drive(0, 784, 0, 0, 100, 100, -1, cyc);
    drain(0);
    chk("rst_win_count", rx_cnt[0] - rx_base[0], 576);
    chk("rst_last_count", last_cnt[0] - lb, 1);
    chk("rst_first_elem24", log0[0][24*8 +: 8], 116);

    // sof at pixel (6,7), then three contiguous frames
    drive(0, 6*28 + 7, 1, 0, 100, 100, -1, cyc);
    drain(0);
    rx_base[0] = rx_cnt[0];
    lb = last_cnt[0];
    drive(0, 3*784, 1, 0, 100, 100, -1, cyc);
    drain(0);
    chk("sof_win_count", rx_cnt[0] - rx_base[0], 3*576);
    chk("sof_last_count", last_cnt[0] - lb, 3);
    chk("sof_cycles", cyc, 3*784);
    chk("sof_first_elem0", log0[0][7:0], 0);
    chk("sof_first_elem24", log0[0][24*8 +: 8], 116);

    repeat (3) @(posedge clk);
    chk("leftover_expected", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
